cluster_step_capture: RTL and testbench

CLUSTER_STEP_CAPTURE -- requirements
Module: cluster_step_capture

---
 rtl/cluster_step_capture.sv | 133 +++++++++++++
 tb/tb_cluster_step_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_step_capture.sv
// cluster_step_capture
//    Holds the architectural state of a cluster and advances it one step at
//    a time. After a start, the combinational output-bit modules get
//    SETTLE_CYC cycles to settle. Their outputs (cluster_o) are then captured
//    into state_q. Steps can be single-shot or continuous. A stall holds the
//    capture, and a stop abandons the step.
//
// Ports
//    clk         single clock, rising edge
//    rst_n       asynchronous active-low reset
//    cluster_o   next-state bits from the output-bit modules
//    init_load   load init_value into state_q (IDLE only)
//    init_value  initial architectural state
//    start       begin stepping (IDLE only)
//    run         1 = continuous stepping, 0 = single step
//    stop        abort stepping (SETTLE/CAPTURE only)
//    stall       hold the capture while high
//    state_q     registered state
//    busy        high in SETTLE or CAPTURE
//    step_done   one-cycle pulse per committed capture
//    step_cnt    committed captures since reset or init_load
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for init_load or start
// SETTLE   | settle_cnt counts down SETTLE_CYC cycles while cluster_o settles
// CAPTURE  | commit cluster_o into state_q unless stalled or stopped

module cluster_step_capture #(
   parameter int OUT_W      = 128,
   parameter int SETTLE_CYC = 3,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OUT_W-1:0] cluster_o,
   input  logic             init_load,
   input  logic [OUT_W-1:0] init_value,
   input  logic             start,
   input  logic             run,
   input  logic             stop,
   input  logic             stall,
   output logic [OUT_W-1:0] state_q,
   output logic             busy,
   output logic             step_done,
   output logic [CNT_W-1:0] step_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2
   } fsm_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   fsm_t             fsm_q, fsm_d;
   logic [3:0]       settle_cnt_q, settle_cnt_d;
   logic [OUT_W-1:0] state_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic             step_done_q, step_done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q        <= ST_IDLE;
         settle_cnt_q <= '0;
         state_q      <= '0;
         step_cnt_q   <= '0;
         step_done_q  <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         settle_cnt_q <= settle_cnt_d;
         state_q      <= state_d;
         step_cnt_q   <= step_cnt_d;
         step_done_q  <= step_done_d;
      end
   end

   always_comb begin
      fsm_d        = fsm_q;
      settle_cnt_d = settle_cnt_q;
      state_d      = state_q;
      step_cnt_d   = step_cnt_q;
      step_done_d  = 1'b0;

      case (fsm_q)
         ST_IDLE: begin
            // init_load wins over a start in the same cycle
            if (init_load) begin
               state_d    = init_value;
               step_cnt_d = '0;
            end else if (start) begin
               fsm_d        = ST_SETTLE;
               settle_cnt_d = SETTLE_LOAD;
            end
         end

         ST_SETTLE: begin
            if (stop) begin
               fsm_d = ST_IDLE;
            end else if (settle_cnt_q == 4'd0) begin
               fsm_d = ST_CAPTURE;
            end else begin
               settle_cnt_d = settle_cnt_q - 4'd1;
            end
         end

         ST_CAPTURE: begin
            // stop beats the capture; a stall holds everything in place
            if (stop) begin
               fsm_d = ST_IDLE;
            end else if (!stall) begin
               state_d     = cluster_o;
               step_cnt_d  = step_cnt_q + CNT_W'(1);
               step_done_d = 1'b1;
               if (run) begin
                  fsm_d        = ST_SETTLE;
                  settle_cnt_d = SETTLE_LOAD;
               end else begin
                  fsm_d = ST_IDLE;
               end
            end
         end

         default: fsm_d = ST_IDLE;
      endcase
   end

   assign busy      = (fsm_q != ST_IDLE);
   assign step_done = step_done_q;
   assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_cluster_step_capture.sv
module tb_cluster_step_capture;

   localparam int OUT_W = 128;
   localparam int SETTLE_CYC = 3;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [OUT_W-1:0] cluster_o;
   logic             init_load;
   logic [OUT_W-1:0] init_value;
   logic             start;
   logic             run;
   logic             stop;
   logic             stall;
   logic [OUT_W-1:0] state_q;
   logic             busy;
   logic             step_done;
   logic [CNT_W-1:0] step_cnt;

   cluster_step_capture #(
      .OUT_W(OUT_W), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cluster_o(cluster_o),
      .init_load(init_load), .init_value(init_value), .start(start),
      .run(run), .stop(stop), .stall(stall), .state_q(state_q),
      .busy(busy), .step_done(step_done), .step_cnt(step_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] st;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   logic [OUT_W-1:0] m_state;
   logic [CNT_W-1:0] m_cnt;

   task automatic chk(input string tag, input logic [OUT_W-1:0] got,
                      input logic [OUT_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every step_done pops one expected commit.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (step_done) begin
            chk("done_twice", 128'(prev_done), 128'(0));
            if (sb.size() == 0) begin
               chk("unexpected_done", 128'(1), 128'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_state", state_q, e.st);
               chk("sb_cnt", 128'(step_cnt), 128'(e.cnt));
            end
         end
         prev_done <= step_done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic do_init(input logic [OUT_W-1:0] v);
      init_value = v;
      init_load  = 1'b1;
      tick;
      init_load  = 1'b0;
      m_state    = v;
      m_cnt      = '0;
      chk("init_state", state_q, v);
      chk("init_cnt", 128'(step_cnt), 128'(0));
   endtask

   // Single step, run=0, no stall: cycle-exact latency check.
   task automatic do_step(input logic [OUT_W-1:0] v);
      exp_t e;
      cluster_o = v;
      m_cnt     = m_cnt + 1'b1;
      e.st      = v;
      e.cnt     = m_cnt;
      sb.push_back(e);
      run   = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < SETTLE_CYC; i++) begin
         chk("step_busy", 128'(busy), 128'(1));
         chk("step_hold", state_q, m_state);
         tick;
      end
      tick;
      chk("step_latency_state", state_q, v);
      chk("step_latency_done", 128'(step_done), 128'(1));
      m_state = v;
      tick;
      chk("step_idle_busy", 128'(busy), 128'(0));
      chk("step_done_low", 128'(step_done), 128'(0));
   endtask

   initial begin
      logic [OUT_W-1:0] v;
      logic [OUT_W-1:0] prev;
      exp_t e;

      rst_n = 1'b0; cluster_o = '0; init_load = 1'b0; init_value = '0;
      start = 1'b0; run = 1'b0; stop = 1'b0; stall = 1'b0;
      m_state = '0; m_cnt = '0;
      #2;
      chk("rst_state", state_q, '0);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(step_done), 128'(0));
      chk("rst_cnt", 128'(step_cnt), 128'(0));
      tick;
      rst_n = 1'b1;
      tick;

      // Single step with init
      do_init({16{8'hA5}});
      do_step({16{8'h5A}});
      chk("single_cnt", 128'(step_cnt), 128'(1));

      // init_load and start together: load wins, stays idle
      init_value = {16{8'h3C}};
      init_load = 1'b1;
      start = 1'b1;
      tick;
      init_load = 1'b0;
      start = 1'b0;
      m_state = {16{8'h3C}};
      m_cnt = '0;
      chk("ldstart_state", state_q, m_state);
      chk("ldstart_busy", 128'(busy), 128'(0));
      chk("ldstart_cnt", 128'(step_cnt), 128'(0));
      tick;
      chk("ldstart_busy2", 128'(busy), 128'(0));

      // Continuous stepping, stall held 2 cycles in each CAPTURE
      run = 1'b1;
      prev = m_state;
      for (int s = 0; s < 3; s++) begin
         v = {$urandom(), $urandom(), $urandom(), $urandom()};
         cluster_o = v;
         m_cnt = m_cnt + 1'b1;
         e.st = v;
         e.cnt = m_cnt;
         sb.push_back(e);
         if (s == 0) begin
            start = 1'b1;
            tick;
            start = 1'b0;
         end
         if (s == 1) init_load = 1'b1;
         tick;
         init_load = 1'b0;
         chk("busy_load_ignored", state_q, prev);
         tick;
         tick;
         stall = 1'b1;
         tick;
         tick;
         stall = 1'b0;
         chk("stall_hold_state", state_q, prev);
         chk("stall_no_done", 128'(step_done), 128'(0));
         if (s == 2) run = 1'b0;
         tick;
         chk("run_done", 128'(step_done), 128'(1));
         chk("run_state", state_q, v);
         prev = v;
      end
      m_state = prev;
      tick;
      chk("run_end_idle", 128'(busy), 128'(0));

      // stop in the cycle CAPTURE would commit
      cluster_o = ~m_state;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      tick;
      stop = 1'b1;
      tick;
      stop = 1'b0;
      chk("stop_busy", 128'(busy), 128'(0));
      chk("stop_state", state_q, m_state);
      chk("stop_cnt", 128'(step_cnt), 128'(m_cnt));
      chk("stop_done", 128'(step_done), 128'(0));

      // stop during SETTLE
      start = 1'b1;
      tick;
      start = 1'b0;
      stop = 1'b1;
      tick;
      stop = 1'b0;
      chk("stop_settle_busy", 128'(busy), 128'(0));
      for (int i = 0; i < 6; i++) tick;
      chk("stop_settle_state", state_q, m_state);

      // step counter wrap
      do_init({8{16'h1234}});
      for (int i = 0; i < 15; i++) begin
         do_step({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      chk("pre_wrap_cnt", 128'(step_cnt), 128'(15));
      do_step({16{8'hC3}});
      chk("wrap_cnt", 128'(step_cnt), 128'(0));

      // reset mid-SETTLE
      cluster_o = {16{8'hFF}};
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      rst_n = 1'b0;
      #1;
      chk("arst_state", state_q, '0);
      chk("arst_busy", 128'(busy), 128'(0));
      chk("arst_done", 128'(step_done), 128'(0));
      chk("arst_cnt", 128'(step_cnt), 128'(0));
      tick;
      rst_n = 1'b1;
      m_state = '0;
      m_cnt = '0;
      for (int i = 0; i < 5; i++) tick;
      chk("arst_wait_idle", 128'(busy), 128'(0));
      chk("arst_no_capture", state_q, '0);
      do_init({16{8'hA5}});
      do_step({16{8'h5A}});
      chk("arst_step_cnt", 128'(step_cnt), 128'(1));

      tick;
      chk("sb_empty", 128'(sb.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
